lfsr_rng: RTL and testbench
===========================

LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 SHALL have parameter LFSR_LEN, default 16: LFSR length; legal values 16, 24, 32 only.
REQ-002 SHALL have parameter NUM_WAYS, default 4: exclusive upper bound of drawn index, 2..256.
REQ-003 SHALL have parameter MAX_TRIES, default 3: rejections allowed before fallback, 0..15.
REQ-004 SHALL have derived constant IDX_W = max(1, clog2(NUM_WAYS)).
REQ-005 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port en  in  1  free-run step enable.
REQ-008 SHALL have port seed_valid  in  1  load seed this cycle.
REQ-009 SHALL have port seed  in  LFSR_LEN  seed value.
REQ-010 SHALL have port req_valid  in  1  draw request.
REQ-011 SHALL have port req_ready  out  1  draw request accepted.
REQ-012 SHALL have port resp_valid  out  1  drawn index valid.
REQ-013 SHALL have port resp_ready  in  1  consumer takes index.
REQ-014 SHALL have port resp_idx  out  IDX_W  drawn index, always < NUM_WAYS.
REQ-015 SHALL have port state  out  LFSR_LEN  current LFSR register, for debug/observation.

Function
REQ-016 LFSR SHALL be Fibonacci XNOR form: on a step, state <= {fb, state[LEN-1:1]}, fb = XNOR of the four package taps for LFSR_LEN.
REQ-017 Taps (1-based, XAPP052): 16 -> 16,15,13,4; 24 -> 24,23,22,17; 32 -> 32,22,2,1.
REQ-018 LFSR SHALL step in any cycle where en=1 or FSM is in DRAW; otherwise hold.
REQ-019 seed_valid SHALL take priority over stepping; loaded value = seed, except all-ones seed (XNOR lockup) SHALL load all-zeros.
REQ-020 FSM states IDLE, DRAW, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE: req_valid=1 -> DRAW, try counter cleared to 0.
REQ-022 DRAW: candidate = state[IDX_W-1:0]; candidate < NUM_WAYS -> latch into resp_idx, go RESP.
REQ-023 DRAW reject with tries < MAX_TRIES -> tries+1, stay DRAW (LFSR stepped, new candidate next cycle).
REQ-024 DRAW reject with tries == MAX_TRIES -> resp_idx = round-robin counter rr, rr <= (rr == NUM_WAYS-1) ? 0 : rr+1, go RESP.
REQ-025 RESP: resp_valid=1, resp_idx stable; resp_ready=1 -> IDLE; otherwise hold.
REQ-026 Minimum latency: request accepted cycle t, resp_valid high at t+2; worst case t+2+MAX_TRIES.
REQ-027 Power-of-two NUM_WAYS SHALL never reject.
REQ-028 Seed load during DRAW SHALL be honoured; draw continues from loaded state.
REQ-029 rr SHALL advance only on fallback.

Reset
REQ-030 Reset SHALL clear state to all-zeros, FSM to IDLE, tries=0, rr=0, resp_idx=0.
REQ-031 Reset outputs: req_ready=1, resp_valid=0, resp_idx=0, state=0.
REQ-032 Reset mid-draw SHALL abort without a response; no resp_valid after release until a new request.

Structure
REQ-033 Package lfsr_pkg SHALL hold the legal-length set, the tap table, a tap-lookup function and the FSM state enum.
REQ-034 Sub-module lfsr_core SHALL implement REQ-016..019 (step, load, lockup guard).
REQ-035 lfsr_rng SHALL instantiate lfsr_core and contain the FSM, try counter and rr counter.
REQ-036 Illegal LFSR_LEN or NUM_WAYS SHALL cause an elaboration error.

Verification
REQ-037 LEN=16, reset released, en=1 one cycle -> state=0x8000.
REQ-038 seed_valid=1, seed=0xFFFF -> state=0x0000 next cycle; seed=0x1234 -> state=0x1234.
REQ-039 NUM_WAYS=4, seed 0x0006, req at t -> resp_valid at t+2, resp_idx=2; resp_ready held low 5 cycles -> idx stable, req_ready=0.
REQ-040 NUM_WAYS=5, MAX_TRIES=1, seed 0x0007 -> first candidate 7 rejected, next 3 accepted, resp_idx=3 at t+3.
REQ-041 NUM_WAYS=5, MAX_TRIES=0, seed 0x0007 -> fallback, resp_idx=0 at t+2, rr=1; repeat -> resp_idx=1.
REQ-042 Reset asserted while in DRAW -> FSM IDLE, resp_valid=0, state=0 immediately (asynchronous).

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random index generator: the legal LFSR
// lengths, their XNOR tap positions, tap lookup helpers and the draw FSM states.
package lfsr_pkg;

    localparam int NUM_LENS = 3;
    localparam int LEGAL_LENS [NUM_LENS] = '{16, 24, 32};

    // Tap positions are 1-based (XAPP052 numbering), four taps per length
    localparam int TAP_TABLE [NUM_LENS][4] = '{
        '{16, 15, 13,  4},
        '{24, 23, 22, 17},
        '{32, 22,  2,  1}
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_RESP = 2'd2
    } rng_state_e;

    function automatic bit lfsr_len_legal(input int len);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_LENS; i++)
            if (LEGAL_LENS[i] == len) ok = 1'b1;
        return ok;
    endfunction

    // Returns the k-th 1-based tap for len; an illegal len yields 1 so the
    // caller still elaborates far enough to hit its parameter error.
    function automatic int lfsr_tap(input int len, input int k);
        int tap;
        tap = 1;
        for (int i = 0; i < NUM_LENS; i++)
            if (LEGAL_LENS[i] == len) tap = TAP_TABLE[i][k];
        return tap;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR register with seed load and all-ones lockup guard.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int LFSR_LEN = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_i,
    input  logic                load_i,
    input  logic [LFSR_LEN-1:0] seed_i,
    output logic [LFSR_LEN-1:0] state_o
);

    localparam int T0 = lfsr_tap(LFSR_LEN, 0) - 1;
    localparam int T1 = lfsr_tap(LFSR_LEN, 1) - 1;
    localparam int T2 = lfsr_tap(LFSR_LEN, 2) - 1;
    localparam int T3 = lfsr_tap(LFSR_LEN, 3) - 1;

    logic [LFSR_LEN-1:0] state_q, state_d;
    logic                fb;

    assign fb      = ~(state_q[T0] ^ state_q[T1] ^ state_q[T2] ^ state_q[T3]);
    assign state_o = state_q;

    // Next state: a seed load wins over a step; all-ones would lock an XNOR LFSR
    always_comb begin
        state_d = state_q;
        if (load_i)
            state_d = (&seed_i) ? '0 : seed_i;
        else if (step_i)
            state_d = {fb, state_q[LFSR_LEN-1:1]};
    end

    // LFSR register, cleared to the all-zeros (legal for XNOR) state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= '0;
        else       state_q <= state_d;
    end

endmodule

// File: rtl/lfsr_rng.sv
// Draws a uniform-ish index < NUM_WAYS from an LFSR by rejection sampling,
// falling back to a round-robin counter after MAX_TRIES rejections.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter  int LFSR_LEN  = 16,
    parameter  int NUM_WAYS  = 4,
    parameter  int MAX_TRIES = 3,
    localparam int IDX_W     = ($clog2(NUM_WAYS) < 1) ? 1 : $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                seed_valid,
    input  logic [LFSR_LEN-1:0] seed,
    input  logic                req_valid,
    output logic                req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDX_W-1:0]    resp_idx,
    output logic [LFSR_LEN-1:0] state
);

    if (!lfsr_len_legal(LFSR_LEN) || NUM_WAYS < 2 || NUM_WAYS > 256 ||
        MAX_TRIES < 0 || MAX_TRIES > 15) begin : g_param_err
        $error("lfsr_rng: illegal LFSR_LEN/NUM_WAYS/MAX_TRIES");
    end

    localparam logic [IDX_W:0]   NW      = NUM_WAYS[IDX_W:0];
    localparam logic [IDX_W-1:0] RR_LAST = IDX_W'(NUM_WAYS - 1);
    localparam logic [3:0]       MT      = 4'(MAX_TRIES);

    rng_state_e       fsm_q, fsm_d;
    logic [3:0]       tries_q, tries_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cand;
    logic             cand_ok;
    logic             drawing;

    lfsr_core #(.LFSR_LEN(LFSR_LEN)) u_core (
        .clk    (clk),
        .reset  (reset),
        .step_i (en | drawing),
        .load_i (seed_valid),
        .seed_i (seed),
        .state_o(state)
    );

    // Candidate is the low bits of the current register; the LFSR steps
    // under it while drawing, so a reject sees a fresh value next cycle.
    assign cand    = state[IDX_W-1:0];
    assign cand_ok = {1'b0, cand} < NW;

    // FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= ST_IDLE;
            tries_q <= '0;
            rr_q    <= '0;
            idx_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            tries_q <= tries_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: accept, retry, or fall back to the round-robin index
    always_comb begin
        fsm_d   = fsm_q;
        tries_d = tries_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        case (fsm_q)
            ST_IDLE: begin
                if (req_valid) begin
                    fsm_d   = ST_DRAW;
                    tries_d = '0;
                end
            end
            ST_DRAW: begin
                if (cand_ok) begin
                    idx_d = cand;
                    fsm_d = ST_RESP;
                end else if (tries_q != MT) begin
                    tries_d = tries_q + 4'd1;
                end else begin
                    idx_d = rr_q;
                    rr_d  = (rr_q == RR_LAST) ? '0 : rr_q + IDX_W'(1);
                    fsm_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) fsm_d = ST_IDLE;
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        req_ready  = (fsm_q == ST_IDLE);
        resp_valid = (fsm_q == ST_RESP);
        drawing    = (fsm_q == ST_DRAW);
        resp_idx   = idx_q;
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// Scoreboard bench for lfsr_rng: a reference model predicts each drawn index
// and its response cycle; a monitor checks them as responses appear.
module tb_lfsr_rng;

    localparam int N  = 5;
    localparam int MT = 1;
    localparam int W  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, seed_valid, req_valid, resp_ready;
    logic [15:0] seed;
    logic        req_ready, resp_valid;
    logic [W-1:0] resp_idx;
    logic [15:0] state;

    logic        p_en, p_sv, p_rv, p_rr;
    logic [15:0] p_seed;
    logic        p_req_ready, p_resp_valid;
    logic [1:0]  p_idx;
    logic [15:0] p_state;

    lfsr_rng #(.LFSR_LEN(16), .NUM_WAYS(N), .MAX_TRIES(MT)) u_dut (
        .clk(clk), .reset(reset), .en(en), .seed_valid(seed_valid), .seed(seed),
        .req_valid(req_valid), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_idx(resp_idx), .state(state)
    );

    lfsr_rng #(.LFSR_LEN(16), .NUM_WAYS(4), .MAX_TRIES(0)) u_p2 (
        .clk(clk), .reset(reset), .en(p_en), .seed_valid(p_sv), .seed(p_seed),
        .req_valid(p_rv), .req_ready(p_req_ready), .resp_valid(p_resp_valid),
        .resp_ready(p_rr), .resp_idx(p_idx), .state(p_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;

    typedef struct { int idx; int first_cyc; } exp_t;
    exp_t sbq[$];

    logic [15:0] m_state;
    int          m_rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference LFSR: shift right; the new top bit is 1 when an even number
    // of the tap bits (16,15,13,4) are set.
    function automatic logic [15:0] m_next(input logic [15:0] s);
        int taps [4] = '{16, 15, 13, 4};
        int ones = 0;
        foreach (taps[k]) ones += int'(s[taps[k]-1]);
        return (s >> 1) | (((ones % 2) == 0) ? 16'h8000 : 16'h0000);
    endfunction

    // Rejection sampling at the model level: k draw cycles, each steps the LFSR
    task automatic model_draw(output int idx, output int k);
        int c;
        idx = -1;
        k   = 0;
        for (int t = 0; t <= MT; t++) begin
            k++;
            c = int'(m_state) % (1 << W);
            m_state = m_next(m_state);
            if (c < N) begin idx = c; break; end
        end
        if (idx < 0) begin
            idx  = m_rr;
            m_rr = (m_rr + 1) % N;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_resp(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done_cnt >= target) begin ok = 1'b1; break; end
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        resp_ready = 1'b0;
        check("resp_handshake_timeout", 32'(ok), 1);
        if (!ok) sbq.delete();
    endtask

    // Issue one request; expectations come from the model unless given
    task automatic issue_req(input int exp_idx, input int exp_k);
        int idx, k, target;
        exp_t e;
        check("req_ready_idle", req_ready, 1);
        model_draw(idx, k);
        e.idx       = (exp_idx >= 0) ? exp_idx : idx;
        e.first_cyc = cyc + 1 + ((exp_k >= 0) ? exp_k : k);
        sbq.push_back(e);
        target = done_cnt + 1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_resp(target);
        check("state_after_draw", state, m_state);
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_valid = 1'b1;
        seed       = s;
        tick();
        seed_valid = 1'b0;
        m_state    = (s == 16'hFFFF) ? 16'h0000 : s;
        check("seed_load", state, m_state);
    endtask

    // Monitor: every cycle a response is shown, check it against the queue head
    initial begin
        bit in_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_resp = 1'b0;
            end else if (resp_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_resp_valid", resp_valid, 0);
                end else begin
                    if (!in_resp) begin
                        check("resp_latency", cyc, sbq[0].first_cyc);
                        in_resp = 1'b1;
                    end
                    check("resp_idx", resp_idx, sbq[0].idx);
                    check("req_ready_in_resp", req_ready, 0);
                    if (resp_ready) begin
                        void'(sbq.pop_front());
                        in_resp = 1'b0;
                        done_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int target;
        exp_t e;
        logic [15:0] r;
        reset = 1'b1;
        en = 0; seed_valid = 0; seed = '0; req_valid = 0; resp_ready = 0;
        p_en = 0; p_sv = 0; p_seed = '0; p_rv = 0; p_rr = 0;
        m_state = '0; m_rr = 0;
        #23;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_idx", resp_idx, 0);
        check("rst_state", state, 0);
        tick();
        reset = 1'b0;
        tick();

        // One enabled step from zero
        en = 1'b1; tick(); en = 1'b0;
        check("first_step", state, 16'h8000);
        m_state = 16'h8000;
        tick();
        check("hold_no_en", state, 16'h8000);

        load_seed(16'hFFFF);
        check("lockup_guard", state, 16'h0000);
        load_seed(16'h1234);
        check("seed_1234", state, 16'h1234);

        // 7 rejected, next candidate 3 accepted, response at t+3
        load_seed(16'h0007);
        issue_req(3, 2);

        // Two rejects in a row -> round-robin fallback, rr advances
        load_seed(16'h000F);
        issue_req(0, 2);
        load_seed(16'h000F);
        issue_req(1, 2);

        // Seed loaded during DRAW replaces the step; draw continues from it
        load_seed(16'h0007);
        e.idx = 2; e.first_cyc = cyc + 3;
        sbq.push_back(e);
        target = done_cnt + 1;
        req_valid = 1'b1; tick(); req_valid = 1'b0;
        seed_valid = 1'b1; seed = 16'h0002; tick(); seed_valid = 1'b0;
        wait_resp(target);
        m_state = m_next(16'h0002);
        check("state_after_seed_in_draw", state, m_state);

        // Randomised mix of seeds, free-run steps and draws
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    r = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    load_seed(r);
                end
                1: begin
                    int n = $urandom_range(1, 5);
                    en = 1'b1;
                    repeat (n) begin tick(); m_state = m_next(m_state); end
                    en = 1'b0;
                    check("free_run", state, m_state);
                end
                default: issue_req(-1, -1);
            endcase
        end

        // Asynchronous reset in the middle of a draw aborts it
        load_seed(16'h0007);
        req_valid = 1'b1; tick(); req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("abort_resp_valid", resp_valid, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_state", state, 0);
        check("abort_idx", resp_idx, 0);
        tick();
        reset = 1'b0;
        m_state = '0; m_rr = 0;
        repeat (6) begin
            tick();
            check("no_resp_after_abort", resp_valid, 0);
        end
        // rr restarted at 0 after reset
        load_seed(16'h000F);
        issue_req(0, 2);

        // Power-of-two ways: candidate always accepted at t+2, held while stalled
        p_seed = 16'h0006; p_sv = 1'b1; tick(); p_sv = 1'b0;
        check("p2_seed", p_state, 16'h0006);
        p_rv = 1'b1; tick(); p_rv = 1'b0;
        check("p2_draw_not_valid", p_resp_valid, 0);
        tick();
        check("p2_valid_t2", p_resp_valid, 1);
        check("p2_idx", p_idx, 2);
        repeat (5) begin
            tick();
            check("p2_hold_valid", p_resp_valid, 1);
            check("p2_hold_idx", p_idx, 2);
            check("p2_hold_req_ready", p_req_ready, 0);
        end
        p_rr = 1'b1; tick(); p_rr = 1'b0;
        check("p2_back_idle", p_req_ready, 1);
        for (int it = 0; it < 8; it++) begin
            r = 16'($urandom);
            p_seed = r; p_sv = 1'b1; tick(); p_sv = 1'b0;
            if (r == 16'hFFFF) r = 16'h0000;
            p_rv = 1'b1; tick(); p_rv = 1'b0;
            tick();
            check("p2_rand_valid", p_resp_valid, 1);
            check("p2_rand_idx", p_idx, 32'(r % 16'd4));
            p_rr = 1'b1; tick(); p_rr = 1'b0;
        end

        repeat (3) tick();
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
